// File: rtl/preemption_timer.sv
// Scheduler quantum timer: counts unstalled RUN cycles and flags expiry (pulse plus sticky pending flag).
// Optional TIMER_PRESCALER_EN divides the tick by Prescale+1; without it every counting cycle is a tick.
module preemption_timer #(
  parameter int CNT_WIDTH       = 16,
  parameter int DEFAULT_QUANTUM = 20,
  parameter int IO_WIDTH        = 2,
  parameter int PRESCALE_WIDTH  = 4
) (
  input  logic                      CLK,
  input  logic                      Reset,
  input  logic                      PREEMP_ON,
  input  logic                      PREEMP_OFF,
  input  logic                      Finalize,
  input  logic [IO_WIDTH-1:0]       IO,
  input  logic                      QuantumLoad,
  input  logic [CNT_WIDTH-1:0]      QuantumValue,
  input  logic                      IntAck,
  input  logic [PRESCALE_WIDTH-1:0] Prescale,
  output logic                      OutOfQuantum,
  output logic                      IntPending,
  output logic                      Active,
  output logic [CNT_WIDTH-1:0]      Count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [CNT_WIDTH-1:0]  r_count;
  logic [CNT_WIDTH-1:0]  r_quantum;
  logic                  r_ooq;
  logic                  r_pending;

  logic                  w_io_busy;
  logic                  w_active;
  logic                  w_restart;
  logic                  w_load;
  logic                  w_count_en;
  logic                  w_tick;
  logic                  w_expire;
  logic [CNT_WIDTH-1:0]  w_count_inc;

  assign w_io_busy   = |IO;
  assign w_active    = (r_state != IDLE);
  assign w_restart   = Finalize && w_active;
  assign w_load      = QuantumLoad && (QuantumValue != '0);
  assign w_count_inc = r_count + CNT_WIDTH'(1);

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_count_en   = 1'b0;
    if (PREEMP_OFF) begin
      w_next_state = IDLE;
    end else if (PREEMP_ON) begin
      w_next_state = RUN;
    end else begin
      case (r_state)
        RUN: begin
          if (w_io_busy) begin
            w_next_state = STALL;
          end else begin
            // Lower-priority controls in the same cycle steal the count slot.
            w_count_en = !w_restart && !w_load;
          end
        end
        STALL: begin
          if (!w_io_busy) begin
            w_next_state = RUN;
          end
        end
        default: w_next_state = r_state;
      endcase
    end
  end

`ifdef TIMER_PRESCALER_EN
  logic [PRESCALE_WIDTH-1:0] r_prescale;

  assign w_tick = w_count_en && (r_prescale == Prescale);

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_prescale <= '0;
    end else if (PREEMP_OFF || PREEMP_ON || w_restart) begin
      r_prescale <= '0;
    end else if (w_count_en) begin
      r_prescale <= w_tick ? '0 : r_prescale + PRESCALE_WIDTH'(1);
    end
  end
`else
  logic w_unused_prescale;

  assign w_unused_prescale = ^Prescale;
  assign w_tick            = w_count_en;
`endif

  // Count stays below the quantum, so expiry always precedes a wrap.
  assign w_expire = w_tick && (w_count_inc >= r_quantum);

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_count <= '0;
    end else if (PREEMP_OFF || PREEMP_ON || w_restart) begin
      r_count <= '0;
    end else if (w_load) begin
      if (QuantumValue <= r_count) begin
        r_count <= '0;
      end
    end else if (w_tick) begin
      r_count <= w_expire ? '0 : w_count_inc;
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_quantum <= CNT_WIDTH'(DEFAULT_QUANTUM);
    end else if (w_load) begin
      r_quantum <= QuantumValue;
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_ooq     <= 1'b0;
      r_pending <= 1'b0;
    end else begin
      r_ooq     <= w_expire;
      r_pending <= w_expire || (r_pending && !IntAck);
    end
  end

  assign OutOfQuantum = r_ooq;
  assign IntPending   = r_pending;
  assign Active       = w_active;
  assign Count        = r_count;

endmodule
